// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants and types for the instruction-fetch front end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   XLEN / ILEN      : address and instruction widths
//   IALIGN           : instruction alignment in bytes (fetch stride)
//   fetch_entry_t    : {pc, inst} pair stored in the prefetch FIFO
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned IALIGN = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Clears the sub-IALIGN bits of an address.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(IALIGN) - XLEN'(1));
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous circular FIFO used for the prefetch queue and the in-flight
// PC queue. The caller guarantees no push when full and no pop when empty.
// Parameters: DEPTH (power of two, >= 2), WIDTH.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   flush_i      empty the FIFO (wins over push/pop)
//   push_i       write push_data_i at the tail
//   push_data_i  tail data
//   pop_i        advance the head
//   head_o       data at the head (meaningful only when count_o != 0)
//   count_o      number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q
  // and consumers mask the head when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: issues word-aligned requests, collects in-order
// responses of arbitrary latency into a DEPTH-entry prefetch FIFO, and hands
// {inst, pc} to decode. A redirect loads a new PC and flushes queued and
// in-flight (stale) instructions.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-IALIGN target raises 'misaligned' and
//               halts fetching until the next aligned redirect
//   undefined : low target bits are forced to zero, no 'misaligned' port
// Parameters: DEPTH (power of two, >= 2), RESET_PC.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   redirect, redirect_pc  load new fetch PC and flush
//   req_valid/ready/addr   fetch request channel to memory
//   rsp_valid, rsp_data    in-order response words (no backpressure)
//   inst_valid/ready       decode handshake on the FIFO head
//   inst, inst_pc          head instruction and its PC
//   misaligned             (macro only) trap status
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t            drop_q,     drop_d;
  logic            halted_q,   halted_d;

  cnt_t            inst_count;
  cnt_t            inflight;
  logic [ENTRY_W-1:0] inst_head_raw;
  fetch_entry_t    inst_head;
  fetch_entry_t    inst_push_entry;
  logic [XLEN-1:0] pcq_head;

  logic            req_fire;
  logic            rsp_keep;
  logic            inst_pop;
  logic [CW:0]     occupancy;

  // Stale requests are still counted in inflight, so they keep reserving
  // FIFO space until their responses have drained.
  assign occupancy = {1'b0, inst_count} + {1'b0, inflight};

  always_comb begin
    req_valid = !reset && !redirect && !halted_q && (occupancy < (CW+1)'(DEPTH));
    req_addr  = fetch_pc_q;
    req_fire  = req_valid && req_ready;

    // A response in the redirect cycle belongs to the old path: discard it.
    rsp_keep  = rsp_valid && !redirect && (drop_q == '0);
    inst_pop  = inst_valid && inst_ready && !redirect;

    inst_push_entry = '{pc: pcq_head, inst: rsp_data};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    halted_d   = halted_q;
    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
      // inflight already includes earlier stale requests, so the new drop
      // count is simply everything still outstanding after this cycle.
      drop_d     = inflight - cnt_t'(rsp_valid);
`ifdef FETCH_MISALIGN_TRAP_EN
      halted_d   = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (req_fire)                    fetch_pc_d = fetch_pc_q + XLEN'(IALIGN);
      if (rsp_valid && drop_q != '0)   drop_d     = drop_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // The trap flag and the halt condition are set and cleared together.
  assign misaligned = halted_q;
`endif

  // Prefetch FIFO of {pc, inst}.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (rsp_keep),
    .push_data_i (inst_push_entry),
    .pop_i       (inst_pop),
    .head_o      (inst_head_raw),
    .count_o     (inst_count)
  );

  // Addresses of accepted requests, popped as responses return; its
  // occupancy is the in-flight request count. It is not flushed on redirect
  // because stale responses still arrive and must pop their entry.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_pc_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_valid),
    .head_o      (pcq_head),
    .count_o     (inflight)
  );

  assign inst_head  = fetch_entry_t'(inst_head_raw);
  assign inst_valid = (inst_count != '0);
  // Mask unreset storage so the outputs read zero when the FIFO is empty.
  assign inst       = inst_valid ? inst_head.inst : '0;
  assign inst_pc    = inst_valid ? inst_head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Randomized self-checking bench for fetch_unit. A queue-based reference model
// tracks the expected fetch PC, the in-flight requests (with a stale flag) and
// the instruction queue; a memory model returns in-order responses with a
// random latency. Directed sequences cover reset, fill/backpressure, redirect
// with stale responses, PC wrap and misaligned redirect.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned  (misaligned),
`endif
    .inst_pc     (inst_pc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory: accepted requests with the cycle their response becomes due.
  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t mem_q[$];

  // Reference model.
  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  flight_t     fl_q[$];      // requests issued and not yet answered
  logic [31:0] iq_q[$];      // PCs of instructions waiting for decode
  logic [31:0] m_pc;
  bit          m_halted;

  int cyc      = 0;
  int accepted = 0;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return addr ^ 32'h5A5A_C3C3;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance model and memory to the values after the coming edge.
  task automatic cycle(input bit rst, input bit rdr, input logic [31:0] rdpc,
                       input bit rq_rdy, input bit in_rdy, input int lat);
    bit      exp_rv, exp_iv;
    flight_t e;
    @(negedge clk);
    reset       = rst;
    redirect    = rdr;
    redirect_pc = rdpc;
    req_ready   = rq_rdy;
    inst_ready  = in_rdy;
    rsp_valid   = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rsp_data    = rsp_valid ? data_of(mem_q[0].addr) : $urandom;
    #1;
    exp_rv = !rst && !rdr && !m_halted && ((iq_q.size() + fl_q.size()) < DEPTH);
    exp_iv = (iq_q.size() != 0);
    check("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", req_addr, m_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("inst_pc", inst_pc, iq_q[0]);
      check("inst", inst, data_of(iq_q[0]));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misaligned", {31'b0, misaligned}, {31'b0, m_halted});
`endif

    // Model update.
    if (rst) begin
      fl_q.delete();
      iq_q.delete();
      m_pc     = RPC;
      m_halted = 1'b0;
    end else if (rdr) begin
      iq_q.delete();
      if (rsp_valid) e = fl_q.pop_front();
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      m_pc = {rdpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      m_halted = (rdpc[1:0] != 2'b00);
`endif
    end else begin
      if (exp_iv && in_rdy) void'(iq_q.pop_front());
      if (rsp_valid) begin
        e = fl_q.pop_front();
        if (!e.stale) iq_q.push_back(e.addr);
      end
      if (exp_rv && rq_rdy) begin
        fl_q.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    // Memory update (driven by what the DUT actually did).
    if (rst) begin
      mem_q.delete();
    end else begin
      if (rsp_valid) void'(mem_q.pop_front());
      if (req_valid && req_ready) begin
        mem_q.push_back('{addr: req_addr, due: cyc + lat});
        accepted++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return RPC + ($urandom_range(0, 255) << 2);
      1:       return 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      2:       return $urandom;
      default: return RPC + 32'h200;
    endcase
  endfunction

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; inst_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    m_pc = RPC; m_halted = 1'b0;

    // Reset state.
    do_reset(3);
    check("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("reset_inst", inst, 32'd0);
    check("reset_inst_pc", inst_pc, 32'd0);
    check("reset_req_valid", {31'b0, req_valid}, 32'd0);

    // First cycle out of reset requests RESET_PC; 1-cycle memory streams.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Fill with decode stalled: exactly DEPTH requests, then resume.
    do_reset(2);
    accepted = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    check("fill_reqs", accepted, DEPTH);
    check("fill_req_valid", {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // 3-cycle memory, redirect with requests in flight.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    cycle(1'b0, 1'b1, 32'h0100_0100, 1'b1, 1'b1, 3);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);

    // Redirect coincident with a response and a head pop.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, rsp_valid && inst_valid, 32'h0100_0040, 1'b1, 1'b1, 1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // PC wrap: drain, redirect to the last word, fetch two.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("wrap_addr_last", req_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("wrap_addr_zero", req_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Misaligned redirect, then an aligned one.
    cycle(1'b0, 1'b1, 32'h0100_0102, 1'b1, 1'b1, 2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
    cycle(1'b0, 1'b1, 32'h0100_0200, 1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);

    // Randomized phases with varying readiness, redirect rate and latency.
    for (int ph = 0; ph < 8; ph++) begin
      int p_rr = $urandom_range(30, 100);
      int p_ir = $urandom_range(20, 100);
      int p_rd = $urandom_range(0, 10);
      int ml   = $urandom_range(1, 4);
      for (int i = 0; i < 250; i++) begin
        bit rst = ($urandom_range(0, 499) == 0);
        bit rdr = ($urandom_range(0, 99) < p_rd);
        cycle(rst, rdr, pick_target(),
              ($urandom_range(0, 99) < p_rr), ($urandom_range(0, 99) < p_ir),
              $urandom_range(1, ml));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
